same_user_seq: RTL and testbench

SAME_USER_SEQ -- requirements
Module: same_user_seq

---
 rtl/same_user_seq.sv | 134 +++++++++++++
 tb/tb_same_user_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/same_user_seq.sv
// same_user_seq: sequential pairwise duplicate-user detector.
// One channel pair is compared per clock from a captured input snapshot.
module same_user_seq #(
    parameter  int USER_W = 3,
    parameter  int N_CH   = 4,
    localparam int P      = N_CH * (N_CH - 1) / 2,
    localparam int IDX_W  = $clog2(N_CH),
    localparam int CNT_W  = $clog2(P + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   in_ready,
    input  logic [N_CH*USER_W-1:0] users,
    input  logic [N_CH-1:0]        ch_en,
    input  logic                   mode,
    output logic                   busy,
    output logic                   done,
    output logic                   dup_found,
    output logic [IDX_W-1:0]       dup_idx_a,
    output logic [IDX_W-1:0]       dup_idx_b,
    output logic [CNT_W-1:0]       dup_count
);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_CH - 2);
    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(N_CH - 1);

    state_t state;
    state_t state_nxt;

    logic [N_CH*USER_W-1:0] cap_users;
    logic [N_CH-1:0]        cap_en;
    logic                   cap_mode;
    logic [IDX_W-1:0]       i_q;
    logic [IDX_W-1:0]       j_q;

    logic [USER_W-1:0]      usr [N_CH];
    logic                   hit;
    logic                   row_end;
    logic                   last_pair;
    logic                   accept;

    for (genvar k = 0; k < N_CH; k++) begin : g_usr
        assign usr[k] = cap_users[k*USER_W +: USER_W];
    end

    assign hit = cap_en[i_q] & cap_en[j_q]
               & (usr[i_q] == usr[j_q]);

    assign row_end   = (j_q == LAST_J);
    assign last_pair = row_end && (i_q == LAST_I);
    assign accept    = (state == IDLE) && start;

    assign in_ready = (state == IDLE);
    assign busy     = (state == CMP);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                // first-match mode leaves on the very edge that finds it
                if (last_pair || (!cap_mode && hit)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_users <= '0;
            cap_en    <= '0;
            cap_mode  <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            dup_found <= 1'b0;
            dup_idx_a <= '0;
            dup_idx_b <= '0;
            dup_count <= '0;
        end else if (accept) begin
            cap_users <= users;
            cap_en    <= ch_en;
            cap_mode  <= mode;
            i_q       <= '0;
            j_q       <= IDX_W'(1);
            dup_found <= 1'b0;
            dup_idx_a <= '0;
            dup_idx_b <= '0;
            dup_count <= '0;
        end else if (state == CMP) begin
            if (hit) begin
                dup_count <= dup_count + CNT_W'(1);
                if (!dup_found) begin
                    dup_found <= 1'b1;
                    dup_idx_a <= i_q;
                    dup_idx_b <= j_q;
                end
            end
            if (row_end) begin
                i_q <= i_q + IDX_W'(1);
                j_q <= i_q + IDX_W'(2);
            end else begin
                j_q <= j_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_same_user_seq.sv
// tb_same_user_seq: randomized and directed checks of same_user_seq
// against a pair-enumerating reference model.
module tb_same_user_seq;

    localparam int USER_W = 3;
    localparam int N_CH   = 4;
    localparam int P      = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [11:0] users = '0;
    logic [3:0]  ch_en = '0;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        dup_found;
    logic [1:0]  dup_idx_a;
    logic [1:0]  dup_idx_b;
    logic [2:0]  dup_count;

    int tests = 0;
    int fails = 0;

    int          o_edge;
    int          o_ndone;
    int          o_busy;
    int          o_nrdy;
    logic        o_f;
    logic [1:0]  o_a;
    logic [1:0]  o_b;
    logic [2:0]  o_c;
    logic        h_f;
    logic [1:0]  h_a;
    logic [1:0]  h_b;
    logic [2:0]  h_c;

    same_user_seq #(.USER_W(USER_W), .N_CH(N_CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_ready  (in_ready),
        .users     (users),
        .ch_en     (ch_en),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .dup_found (dup_found),
        .dup_idx_a (dup_idx_a),
        .dup_idx_b (dup_idx_b),
        .dup_count (dup_count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pack(input int u0, input int u1,
                                         input int u2, input int u3);
        return {3'(u3), 3'(u2), 3'(u1), 3'(u0)};
    endfunction

    // Walk pairs in lexicographic order; m is the index of the last pair looked at.
    task automatic model(input logic [11:0] u, input logic [3:0] en,
                         input logic md, output int m, output logic f,
                         output logic [1:0] a, output logic [1:0] b,
                         output logic [2:0] c);
        int  idx = 0;
        bit  stop = 0;
        int  cnt = 0;
        m = 0; f = 0; a = 0; b = 0;
        for (int i = 0; i < N_CH; i++) begin
            for (int j = i + 1; j < N_CH; j++) begin
                if (!stop) begin
                    if (en[i] && en[j] &&
                        u[i*USER_W +: USER_W] == u[j*USER_W +: USER_W]) begin
                        cnt++;
                        if (!f) begin
                            f = 1; a = 2'(i); b = 2'(j);
                        end
                    end
                    m = idx;
                    idx++;
                    if (!md && f) stop = 1;
                end
            end
        end
        c = 3'(cnt);
    endtask

    // Drives one scan and records what the DUT showed; checking is left to callers.
    task automatic do_scan(input logic [11:0] u, input logic [3:0] en,
                           input logic md, input bit disturb);
        @(negedge clk);
        users = u; ch_en = en; mode = md; start = 1'b1;
        o_edge = -1; o_ndone = 0; o_busy = 0; o_nrdy = 0;
        o_f = 0; o_a = 0; o_b = 0; o_c = 0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < P + 4; k++) begin
            if (k > 0) @(negedge clk);
            if (busy) o_busy++;
            if (!in_ready) o_nrdy++;
            if (done) begin
                o_ndone++;
                if (o_edge < 0) begin
                    o_edge = k;
                    o_f = dup_found; o_a = dup_idx_a;
                    o_b = dup_idx_b; o_c = dup_count;
                end
            end
            if (disturb && k == 0) begin
                users = 12'($urandom); ch_en = 4'($urandom);
                mode = ~md; start = 1'b1;
            end
            if (disturb && k == 1) begin
                start = 1'b0; users = 12'($urandom);
            end
        end
        h_f = dup_found; h_a = dup_idx_a; h_b = dup_idx_b; h_c = dup_count;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if ({in_ready, busy, done, dup_found, dup_idx_a, dup_idx_b, dup_count}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0}) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b busy=%b done=%b f=%b a=%0d b=%0d c=%0d, want 1 0 0 0 0 0 0",
                     in_ready, busy, done, dup_found, dup_idx_a, dup_idx_b, dup_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [11:0] u;
        logic [3:0]  en;
        logic        md;
        int          e;
        logic        f;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [2:0]  c;
    } vec_t;

    task automatic test_directed();
        vec_t v [7];
        v[0] = '{pack(3,5,3,1), 4'b1111, 1'b0, 2, 1'b1, 2'd0, 2'd2, 3'd1};
        v[1] = '{pack(3,5,3,1), 4'b1111, 1'b1, 6, 1'b1, 2'd0, 2'd2, 3'd1};
        v[2] = '{pack(0,1,2,7), 4'b1111, 1'b1, 6, 1'b0, 2'd0, 2'd0, 3'd0};
        v[3] = '{pack(4,4,4,4), 4'b0011, 1'b1, 6, 1'b1, 2'd0, 2'd1, 3'd1};
        v[4] = '{pack(6,6,6,6), 4'b1111, 1'b1, 6, 1'b1, 2'd0, 2'd1, 3'd6};
        v[5] = '{pack(6,6,6,6), 4'b0001, 1'b1, 6, 1'b0, 2'd0, 2'd0, 3'd0};
        v[6] = '{pack(6,6,6,6), 4'b1111, 1'b0, 1, 1'b1, 2'd0, 2'd1, 3'd1};
        foreach (v[n]) begin
            do_scan(v[n].u, v[n].en, v[n].md, 0);
            tests++;
            if (o_edge != v[n].e || o_ndone != 1) begin
                fails++;
                $display("FAIL dir[%0d] latency: got edge=%0d pulses=%0d, want edge=%0d pulses=1",
                         n, o_edge, o_ndone, v[n].e);
            end
            tests++;
            if ({o_f, o_a, o_b, o_c} !== {v[n].f, v[n].a, v[n].b, v[n].c}) begin
                fails++;
                $display("FAIL dir[%0d] result: got f=%b a=%0d b=%0d c=%0d, want f=%b a=%0d b=%0d c=%0d",
                         n, o_f, o_a, o_b, o_c, v[n].f, v[n].a, v[n].b, v[n].c);
            end
            tests++;
            if ({h_f, h_a, h_b, h_c} !== {v[n].f, v[n].a, v[n].b, v[n].c}) begin
                fails++;
                $display("FAIL dir[%0d] hold: got f=%b a=%0d b=%0d c=%0d, want f=%b a=%0d b=%0d c=%0d",
                         n, h_f, h_a, h_b, h_c, v[n].f, v[n].a, v[n].b, v[n].c);
            end
        end
    endtask

    task automatic test_random(input bit disturb, input int iters);
        logic [11:0] u;
        logic [3:0]  en;
        logic        md;
        int          m;
        logic        ef;
        logic [1:0]  ea;
        logic [1:0]  eb;
        logic [2:0]  ec;
        for (int n = 0; n < iters; n++) begin
            u  = pack($urandom_range(0, 3), $urandom_range(0, 7),
                      $urandom_range(0, 3), $urandom_range(0, 7));
            en = 4'($urandom);
            md = 1'($urandom);
            model(u, en, md, m, ef, ea, eb, ec);
            do_scan(u, en, md, disturb);
            tests++;
            if (o_edge != m + 1 || o_ndone != 1) begin
                fails++;
                $display("FAIL rnd%0d[%0d] latency: got edge=%0d pulses=%0d, want edge=%0d pulses=1",
                         disturb, n, o_edge, o_ndone, m + 1);
            end
            tests++;
            if (o_busy != m + 1 || o_nrdy != m + 2) begin
                fails++;
                $display("FAIL rnd%0d[%0d] handshake: got busy=%0d notready=%0d, want %0d %0d",
                         disturb, n, o_busy, o_nrdy, m + 1, m + 2);
            end
            tests++;
            if ({o_f, o_a, o_b, o_c} !== {ef, ea, eb, ec} ||
                {h_f, h_a, h_b, h_c} !== {ef, ea, eb, ec}) begin
                fails++;
                $display("FAIL rnd%0d[%0d] result: got f=%b a=%0d b=%0d c=%0d held c=%0d, want f=%b a=%0d b=%0d c=%0d",
                         disturb, n, o_f, o_a, o_b, o_c, h_c, ef, ea, eb, ec);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int seen = 0;
        @(negedge clk);
        users = pack(6, 6, 6, 6); ch_en = 4'b1111; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, busy, done, dup_found, dup_idx_a, dup_idx_b, dup_count}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0}) begin
            fails++;
            $display("FAIL abort_state: got rdy=%b busy=%b done=%b f=%b a=%0d b=%0d c=%0d, want 1 0 0 0 0 0 0",
                     in_ready, busy, done, dup_found, dup_idx_a, dup_idx_b, dup_count);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL abort_no_done: got %0d done cycles, want 0", seen);
        end
        do_scan(pack(1, 2, 1, 2), 4'b1111, 1'b1, 0);
        tests++;
        if (o_edge != P || {o_f, o_a, o_b, o_c} !== {1'b1, 2'd0, 2'd2, 3'd2}) begin
            fails++;
            $display("FAIL after_abort: got edge=%0d f=%b a=%0d b=%0d c=%0d, want edge=6 f=1 a=0 b=2 c=2",
                     o_edge, o_f, o_a, o_b, o_c);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(0, 60);
        test_random(1, 30);
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
